fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and drives the combinational instruction ROM. It buffers fetched words in a small queue with a valid/ready handshake to decode, and applies branch redirects with a queue flush. It detects misaligned or out-of-bounds fetch addresses and enters a sticky fault state. It sits between the branch/control logic and decode, with the ROM hanging off its address port.

---
 rtl/fetch_sequencer_pkg.sv | 26 ++
 rtl/fetch_sequencer_if.sv | 16 +
 rtl/fetch_sequencer_queue.sv | 60 ++++++
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
//   fetch_state_t : FSM encoding (FETCH, FAULT)
//   fetch_entry_t : one queued fetch, byte address plus instruction word
//   addr_legal()  : word-aligned and the whole word lies inside the ROM
package fetch_pkg;

  localparam int unsigned DEF_MEM_SIZE = 1024;
  localparam int unsigned DEF_QDEPTH   = 2;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  // 17-bit sum so an address near 16'hFFFF cannot wrap back into range
  function automatic logic addr_legal(input logic [15:0] addr, input logic [16:0] limit);
    return (addr[1:0] == 2'b00) && ((17'(addr) + 17'd3) < limit);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-to-decode handshake bundle.
//   out_valid : queue head valid (fetch -> decode)
//   out_ready : decode accepts head (decode -> fetch)
//   out_instr : head instruction word
//   out_pc    : byte address of head instruction
interface fetch_sequencer_if;

  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_sequencer_queue.sv
// fetch_queue: small synchronous FIFO of fetch entries.
//   push/wdata : enqueue one entry (caller guarantees space, or a same-cycle pop)
//   pop        : dequeue head (caller guarantees non-empty)
//   flush      : drop all entries; wins over push and pop
//   full/empty : occupancy flags decoded from the count register
//   head       : entry at the read pointer
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = DEF_QDEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t    mem [QDEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  // Pointers wrap naturally because depth is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(QDEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, drives the combinational ROM, queues fetched
// words toward decode, applies redirects with a flush and traps bad addresses.
//   clk, reset         : clock, async active-high reset
//   imem_addr/instr    : ROM address (= PC) and combinational read data
//   redirect_valid/pc  : load PC and flush queue this cycle
//   halt               : freeze PC and pushes; queue still drains
//   dec                : decode handshake (master side)
//   fault / fault_pc   : sticky fault flag and captured offending address
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_SIZE = DEF_MEM_SIZE,
  parameter int unsigned QDEPTH   = DEF_QDEPTH,
  parameter logic [15:0] RESET_PC = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic [15:0]        imem_addr,
  input  logic [15:0]        imem_instr,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_pc,
  input  logic               halt,
  fetch_sequencer_if.master  dec,
  output logic               fault,
  output logic [15:0]        fault_pc
);

  localparam logic [16:0] MEM_LIMIT = 17'(MEM_SIZE);
  localparam logic [0:0]  S_FETCH   = 1'(FETCH);
  localparam logic [0:0]  S_FAULT   = 1'(FAULT);

  logic [0:0]   state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         fault_d;
  logic [15:0]  fault_pc_d;
  logic         push_c, pop_c, full, empty;
  fetch_entry_t head;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .flush (redirect_valid),
    .wdata ('{pc: pc_q, instr: imem_instr}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign imem_addr     = pc_q;
  assign dec.out_valid = ~empty;
  assign dec.out_pc    = head.pc;
  assign dec.out_instr = head.instr;

  assign pop_c  = dec.out_valid & dec.out_ready;
  assign push_c = (state_q == S_FETCH) & ~redirect_valid & ~halt &
                  addr_legal(pc_q, MEM_LIMIT) & (~full | pop_c);

  // State, PC and fault registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fault    <= fault_d;
      fault_pc <= fault_pc_d;
    end
  end

  // Next state: redirect first, then sequential fetch / fault detection
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault;
    fault_pc_d = fault_pc;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (addr_legal(redirect_pc, MEM_LIMIT)) begin
        state_d = S_FETCH;
        fault_d = 1'b0;
      end else begin
        state_d    = S_FAULT;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (push_c) begin
            pc_d = pc_q + 16'd4;
          end else if (~halt && !addr_legal(pc_q, MEM_LIMIT)) begin
            state_d    = S_FAULT;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
          end
        end
        default: state_d = S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst0 = 1'b0, rst1 = 1'b0;
  logic        halt0 = 1'b0, halt1 = 1'b0;
  logic        rv0 = 1'b0, rv1 = 1'b0;
  logic [15:0] rpc0 = 16'h0, rpc1 = 16'h0;
  logic [15:0] addr0, addr1, instr0, instr1, fpc0, fpc1;
  logic        f0, f1;
  int          total = 0;
  int          bad = 0;

  fetch_sequencer_if dif0();
  fetch_sequencer_if dif1();

  // ROM contents: word at byte address a
  function automatic logic [15:0] rom(input logic [15:0] a);
    return 16'hC000 + (a >> 2);
  endfunction

  assign instr0 = rom(addr0);
  assign instr1 = rom(addr1);

  always #5 clk = ~clk;

  fetch_sequencer #(.MEM_SIZE(1024), .QDEPTH(2), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .reset(rst0), .imem_addr(addr0), .imem_instr(instr0),
    .redirect_valid(rv0), .redirect_pc(rpc0), .halt(halt0),
    .dec(dif0), .fault(f0), .fault_pc(fpc0)
  );

  fetch_sequencer #(.MEM_SIZE(1024), .QDEPTH(2), .RESET_PC(16'h03F8)) u_hi (
    .clk(clk), .reset(rst1), .imem_addr(addr1), .imem_instr(instr1),
    .redirect_valid(rv1), .redirect_pc(rpc1), .halt(halt1),
    .dec(dif1), .fault(f1), .fault_pc(fpc1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    dif0.out_ready = 1'b1;
    #1 rst0 = 1'b1;
    #2;
    total++; if (dif0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", dif0.out_valid); end
    total++; if (f0 !== 1'b0) begin bad++; $display("FAIL reset_fault got %b exp 0", f0); end
    total++; if (fpc0 !== 16'h0) begin bad++; $display("FAIL reset_fault_pc got %h exp 0000", fpc0); end
    total++; if (addr0 !== 16'h0) begin bad++; $display("FAIL reset_addr got %h exp 0000", addr0); end
    tick();
    rst0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (dif0.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got %b exp 1", i, dif0.out_valid); end
      total++; if (dif0.out_pc !== 16'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got %h exp %h", i, dif0.out_pc, 16'(4 * i)); end
      total++; if (dif0.out_instr !== rom(16'(4 * i))) begin bad++; $display("FAIL stream_instr[%0d] got %h exp %h", i, dif0.out_instr, rom(16'(4 * i))); end
    end
  endtask

  task automatic test_backpressure;
    rst0 = 1'b1;
    #1 rst0 = 1'b0;
    dif0.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (dif0.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got %b exp 1", dif0.out_valid); end
    total++; if (dif0.out_pc !== 16'h0) begin bad++; $display("FAIL bp_head_pc got %h exp 0000", dif0.out_pc); end
    total++; if (dif0.out_instr !== rom(16'h0)) begin bad++; $display("FAIL bp_head_instr got %h exp %h", dif0.out_instr, rom(16'h0)); end
    total++; if (addr0 !== 16'h8) begin bad++; $display("FAIL bp_pc_stall got %h exp 0008", addr0); end
    dif0.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      total++; if (dif0.out_pc !== 16'(4 * i)) begin bad++; $display("FAIL bp_release_pc[%0d] got %h exp %h", i, dif0.out_pc, 16'(4 * i)); end
    end
  endtask

  task automatic test_redirect;
    dif0.out_ready = 1'b0;
    tick();
    tick();
    total++; if (addr0 !== 16'h14) begin bad++; $display("FAIL rd_full_pc got %h exp 0014", addr0); end
    rv0 = 1'b1; rpc0 = 16'h0040;
    tick();
    rv0 = 1'b0;
    total++; if (dif0.out_valid !== 1'b0) begin bad++; $display("FAIL rd_flush_valid got %b exp 0", dif0.out_valid); end
    total++; if (addr0 !== 16'h40) begin bad++; $display("FAIL rd_pc_load got %h exp 0040", addr0); end
    tick();
    total++; if (dif0.out_valid !== 1'b1) begin bad++; $display("FAIL rd_target_valid got %b exp 1", dif0.out_valid); end
    total++; if (dif0.out_pc !== 16'h40) begin bad++; $display("FAIL rd_target_pc got %h exp 0040", dif0.out_pc); end
    total++; if (dif0.out_instr !== rom(16'h40)) begin bad++; $display("FAIL rd_target_instr got %h exp %h", dif0.out_instr, rom(16'h40)); end
  endtask

  task automatic test_misaligned;
    rv0 = 1'b1; rpc0 = 16'h0006;
    tick();
    rv0 = 1'b0;
    total++; if (f0 !== 1'b1) begin bad++; $display("FAIL mis_fault got %b exp 1", f0); end
    total++; if (fpc0 !== 16'h6) begin bad++; $display("FAIL mis_fault_pc got %h exp 0006", fpc0); end
    total++; if (dif0.out_valid !== 1'b0) begin bad++; $display("FAIL mis_flush got %b exp 0", dif0.out_valid); end
    total++; if (addr0 !== 16'h6) begin bad++; $display("FAIL mis_addr got %h exp 0006", addr0); end
    tick();
    total++; if (dif0.out_valid !== 1'b0) begin bad++; $display("FAIL mis_no_push got %b exp 0", dif0.out_valid); end
    halt0 = 1'b1; rv0 = 1'b1; rpc0 = 16'h0020;
    tick();
    rv0 = 1'b0;
    total++; if (f0 !== 1'b0) begin bad++; $display("FAIL halt_fault_clear got %b exp 0", f0); end
    total++; if (addr0 !== 16'h20) begin bad++; $display("FAIL halt_pc_load got %h exp 0020", addr0); end
    tick();
    tick();
    total++; if (dif0.out_valid !== 1'b0) begin bad++; $display("FAIL halt_no_push got %b exp 0", dif0.out_valid); end
    total++; if (addr0 !== 16'h20) begin bad++; $display("FAIL halt_pc_frozen got %h exp 0020", addr0); end
    halt0 = 1'b0;
    tick();
    total++; if (dif0.out_pc !== 16'h20 || dif0.out_valid !== 1'b1) begin bad++; $display("FAIL halt_resume got v=%b pc=%h exp v=1 pc=0020", dif0.out_valid, dif0.out_pc); end
    total++; if (addr0 !== 16'h24) begin bad++; $display("FAIL halt_resume_pc got %h exp 0024", addr0); end
  endtask

  task automatic test_reset_midstream;
    tick();
    total++; if (dif0.out_pc !== 16'h20 || addr0 !== 16'h28) begin bad++; $display("FAIL mid_prefill got pc=%h addr=%h exp 0020/0028", dif0.out_pc, addr0); end
    #2 rst0 = 1'b1;
    #1;
    total++; if (dif0.out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got %b exp 0", dif0.out_valid); end
    total++; if (f0 !== 1'b0 || fpc0 !== 16'h0) begin bad++; $display("FAIL mid_fault got %b/%h exp 0/0000", f0, fpc0); end
    total++; if (addr0 !== 16'h0) begin bad++; $display("FAIL mid_addr got %h exp 0000", addr0); end
    tick();
    rst0 = 1'b0;
    tick();
    total++; if (dif0.out_valid !== 1'b1 || dif0.out_pc !== 16'h0) begin bad++; $display("FAIL mid_restart got v=%b pc=%h exp v=1 pc=0000", dif0.out_valid, dif0.out_pc); end
  endtask

  task automatic test_end_of_rom;
    dif1.out_ready = 1'b1;
    tick();
    rst1 = 1'b0;
    tick();
    total++; if (dif1.out_pc !== 16'h3F8 || dif1.out_instr !== rom(16'h3F8)) begin bad++; $display("FAIL eor_first got %h/%h exp 03f8/%h", dif1.out_pc, dif1.out_instr, rom(16'h3F8)); end
    tick();
    total++; if (dif1.out_pc !== 16'h3FC || dif1.out_valid !== 1'b1) begin bad++; $display("FAIL eor_last got v=%b pc=%h exp v=1 pc=03fc", dif1.out_valid, dif1.out_pc); end
    tick();
    total++; if (f1 !== 1'b1 || fpc1 !== 16'h400) begin bad++; $display("FAIL eor_fault got %b/%h exp 1/0400", f1, fpc1); end
    total++; if (dif1.out_valid !== 1'b0) begin bad++; $display("FAIL eor_drained got %b exp 0", dif1.out_valid); end
    tick();
    total++; if (dif1.out_valid !== 1'b0 || addr1 !== 16'h400) begin bad++; $display("FAIL eor_hold got v=%b addr=%h exp v=0 addr=0400", dif1.out_valid, addr1); end
    rv1 = 1'b1; rpc1 = 16'h0000;
    tick();
    rv1 = 1'b0;
    total++; if (f1 !== 1'b0 || addr1 !== 16'h0) begin bad++; $display("FAIL eor_recover got %b/%h exp 0/0000", f1, addr1); end
    tick();
    total++; if (dif1.out_valid !== 1'b1 || dif1.out_pc !== 16'h0) begin bad++; $display("FAIL eor_resume got v=%b pc=%h exp v=1 pc=0000", dif1.out_valid, dif1.out_pc); end
  endtask

  initial begin
    dif0.out_ready = 1'b0;
    dif1.out_ready = 1'b0;
    #1 rst1 = 1'b1;
    test_reset();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_reset_midstream();
    test_end_of_rom();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
